// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Control word layout: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write}.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
    } ctrl_t;

    // Free-running pipeline: everything advances, nothing is discarded.
    localparam ctrl_t CtrlDefault = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        if_id_flush:  1'b0,
        id_ex_write:  1'b1,
        id_ex_bubble: 1'b0,
        ex_mem_write: 1'b1
    };

    // Held in reset: registers closed, NOPs presented at IF/ID and ID/EX.
    localparam ctrl_t CtrlNop = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        if_id_flush:  1'b1,
        id_ex_write:  1'b0,
        id_ex_bubble: 1'b1,
        ex_mem_write: 1'b0
    };

    localparam ctrl_t CtrlFreeze = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        if_id_flush:  1'b0,
        id_ex_write:  1'b0,
        id_ex_bubble: 1'b0,
        ex_mem_write: 1'b0
    };

    localparam ctrl_t CtrlFlush = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        if_id_flush:  1'b1,
        id_ex_write:  1'b1,
        id_ex_bubble: 1'b1,
        ex_mem_write: 1'b1
    };

    // Hold PC and IF/ID, insert one bubble behind the load.
    localparam ctrl_t CtrlLoadUse = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        if_id_flush:  1'b0,
        id_ex_write:  1'b1,
        id_ex_bubble: 1'b1,
        ex_mem_write: 1'b1
    };

endpackage

// File: rtl/pipeline_stall_unit_stall_wait_timer.sv
// Memory-wait FSM: counts freeze cycles, forces release after MAX_WAIT and
// latches a sticky timeout flag.
module stall_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_pending,
    output state_e        state,
    output logic [CW-1:0] wait_cnt,
    output logic          force_release,
    output logic          mem_timeout
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    assign force_release = (state_q == MEM_WAIT) && (cnt_q == MaxCnt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (mem_pending) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_pending) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (force_release) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign wait_cnt    = cnt_q;
    assign mem_timeout = timeout_q;

endmodule

// File: rtl/pipeline_stall_unit.sv
// Stall/flush controller for the 5-stage core: memory freeze > branch flush > load-use.
// Define STALL_STATS_EN to add saturating stall statistic counters.
module pipeline_stall_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_EX_memread,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic                  IF_ID_uses_rs2,
    input  logic                  EX_MEM_memreq,
    input  logic                  dmem_ready,
    input  logic                  branch_taken,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0]      load_stall_cnt,
    output logic [CNT_W-1:0]      mem_stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_write,
    output logic                  ID_EX_bubble,
    output logic                  EX_MEM_write,
    output logic                  mem_timeout
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    state_e        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_pending;
    logic          force_release;
    logic          mem_freeze;
    logic          load_use;
    ctrl_t         ctrl;

    assign mem_pending = EX_MEM_memreq && !dmem_ready;
    assign mem_freeze  = mem_pending && !force_release;

    // r0 never carries a dependency; rs2 only matters when the ID op reads it.
    assign load_use = ID_EX_memread && (ID_EX_rd != '0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    stall_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .mem_pending   (mem_pending),
        .state         (state),
        .wait_cnt      (wait_cnt),
        .force_release (force_release),
        .mem_timeout   (mem_timeout)
    );

    always_comb begin
        ctrl = CtrlDefault;
        if (rst) begin
            ctrl = CtrlNop;
        end else if (mem_freeze) begin
            ctrl = CtrlFreeze;
        end else if (branch_taken) begin
            ctrl = CtrlFlush;
        end else if (load_use) begin
            ctrl = CtrlLoadUse;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign IF_ID_write  = ctrl.if_id_write;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EX_write  = ctrl.id_ex_write;
    assign ID_EX_bubble = ctrl.id_ex_bubble;
    assign EX_MEM_write = ctrl.ex_mem_write;

`ifdef STALL_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] load_q, mem_q, flush_q;
    logic             load_act, mem_act, flush_act;

    assign mem_act   = mem_freeze;
    assign flush_act = !mem_freeze && branch_taken;
    assign load_act  = !mem_freeze && !branch_taken && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_q  <= '0;
            mem_q   <= '0;
            flush_q <= '0;
        end else begin
            if (load_act && load_q != CntMax) load_q <= load_q + CNT_W'(1);
            if (mem_act && mem_q != CntMax) mem_q <= mem_q + CNT_W'(1);
            if (flush_act && flush_q != CntMax) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign load_stall_cnt = load_q;
    assign mem_stall_cnt  = mem_q;
    assign flush_cnt      = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Scoreboard bench for pipeline_stall_unit: driver queues hand-computed control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_stall_unit;
    import pipe_ctrl_pkg::*;

    // Expected control words {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w}
    localparam logic [5:0] E_DEF = 6'b110101;
    localparam logic [5:0] E_NOP = 6'b001010;
    localparam logic [5:0] E_FRZ = 6'b000000;
    localparam logic [5:0] E_FLS = 6'b111111;
    localparam logic [5:0] E_LU  = 6'b000111;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_EX_memread;
    logic [2:0] ID_EX_rd, IF_ID_rs1, IF_ID_rs2;
    logic       IF_ID_uses_rs2, EX_MEM_memreq, dmem_ready, branch_taken;
    logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write;
    logic       mem_timeout;
`ifdef STALL_STATS_EN
    logic [15:0] load_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] ctrl;
        logic       to;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    pipeline_stall_unit #(
        .MAX_WAIT (16),
        .CNT_W    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_EX_memread  (ID_EX_memread),
        .ID_EX_rd       (ID_EX_rd),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .IF_ID_uses_rs2 (IF_ID_uses_rs2),
        .EX_MEM_memreq  (EX_MEM_memreq),
        .dmem_ready     (dmem_ready),
        .branch_taken   (branch_taken),
`ifdef STALL_STATS_EN
        .load_stall_cnt (load_stall_cnt),
        .mem_stall_cnt  (mem_stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_write    (ID_EX_write),
        .ID_EX_bubble   (ID_EX_bubble),
        .EX_MEM_write   (EX_MEM_write),
        .mem_timeout    (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] got;
            e = exp_q.pop_front();
            got = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write};
            check({e.name, " ctrl"}, {26'd0, got}, {26'd0, e.ctrl});
            check({e.name, " timeout"}, {31'd0, mem_timeout}, {31'd0, e.to});
        end
    end

    task automatic apply(input logic r, input logic mr, input logic [2:0] rd, input logic [2:0] s1,
                         input logic [2:0] s2, input logic u2, input logic mq, input logic rdy,
                         input logic br, input logic [5:0] ec, input logic et, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ID_EX_memread = mr; ID_EX_rd = rd; IF_ID_rs1 = s1; IF_ID_rs2 = s2;
        IF_ID_uses_rs2 = u2; EX_MEM_memreq = mq; dmem_ready = rdy; branch_taken = br;
        e.ctrl = ec; e.to = et; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] ec, input logic et, input string nm);
        apply(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, et, nm);
    endtask

    initial begin
        rst = 1'b1; ID_EX_memread = 1'b0; ID_EX_rd = '0; IF_ID_rs1 = '0; IF_ID_rs2 = '0;
        IF_ID_uses_rs2 = 1'b0; EX_MEM_memreq = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;

        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NOP, 1'b0, "reset0");
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NOP, 1'b0, "reset1");
        idle(E_DEF, 1'b0, "run_default");

        // Load-use on rs1, then clears.
        apply(0, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 0, E_LU, 1'b0, "lu_rs1");
        idle(E_DEF, 1'b0, "lu_after");
        // r0 destination and unused rs2 never stall; used rs2 does.
        apply(0, 1, 3'd0, 3'd0, 3'd0, 1, 0, 0, 0, E_DEF, 1'b0, "lu_r0");
        apply(0, 1, 3'd5, 3'd1, 3'd5, 0, 0, 0, 0, E_DEF, 1'b0, "lu_rs2_unused");
        apply(0, 1, 3'd5, 3'd1, 3'd5, 1, 0, 0, 0, E_LU, 1'b0, "lu_rs2_used");

        // Three-cycle memory wait, release on the fourth.
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b0, "mem_wait");
        apply(0, 0, 0, 0, 0, 0, 1, 1, 0, E_DEF, 1'b0, "mem_release");
        idle(E_DEF, 1'b0, "mem_after");
        check("state_run_after_wait", {31'd0, dut.state == RUN}, 32'd1);
        check("wait_cnt_zero_after_wait", 32'(dut.wait_cnt), 32'd0);

        // Priority: flush beats load-use; freeze beats both; held branch acts on release.
        apply(0, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 1, E_FLS, 1'b0, "prio_flush");
        apply(0, 1, 3'd3, 3'd3, 3'd0, 0, 1, 0, 1, E_FRZ, 1'b0, "prio_freeze");
        apply(0, 1, 3'd3, 3'd3, 3'd0, 0, 1, 1, 1, E_FLS, 1'b0, "prio_release_flush");
        idle(E_DEF, 1'b0, "prio_after");
`ifdef STALL_STATS_EN
        check("load_stall_cnt", 32'(load_stall_cnt), 32'd2);
        check("flush_cnt", 32'(flush_cnt), 32'd2);
        check("mem_stall_cnt", 32'(mem_stall_cnt), 32'd4);
`endif

        // Timeout: 16 freeze cycles, forced release on the 17th, sticky flag after.
        for (int i = 0; i < 16; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b0, "to_freeze");
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_DEF, 1'b0, "to_force_release");
        for (int i = 0; i < 3; i++) idle(E_DEF, 1'b1, "to_sticky");

        // Back-to-back accesses re-enter the wait with a fresh count.
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b1, "b2b_freeze0");
        apply(0, 0, 0, 0, 0, 0, 1, 1, 0, E_DEF, 1'b1, "b2b_release0");
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b1, "b2b_freeze1");
        check("b2b_wait_cnt_fresh", 32'(dut.wait_cnt), 32'd0);
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b1, "b2b_freeze2");
        check("b2b_wait_cnt_one", 32'(dut.wait_cnt), 32'd1);
        apply(0, 0, 0, 0, 0, 0, 1, 1, 0, E_DEF, 1'b1, "b2b_release1");
        idle(E_DEF, 1'b1, "b2b_after");

        // Reset in wait cycle 5: outputs forced to NOP, timeout cleared on the edge.
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ, 1'b1, "rw_freeze");
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0, E_NOP, 1'b1, "rw_reset0");
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0, E_NOP, 1'b0, "rw_reset1");
        idle(E_DEF, 1'b0, "rw_after");
        check("rw_state_run", {31'd0, dut.state == RUN}, 32'd1);
        check("rw_wait_cnt_zero", 32'(dut.wait_cnt), 32'd0);
`ifdef STALL_STATS_EN
        check("rw_load_cnt_zero", 32'(load_stall_cnt), 32'd0);
        check("rw_mem_cnt_zero", 32'(mem_stall_cnt), 32'd0);
        check("rw_flush_cnt_zero", 32'(flush_cnt), 32'd0);
`endif
        idle(E_DEF, 1'b0, "final_idle");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
